// File: rtl/mio_pkg.sv
// Shared types and constants for the MCtrl memory/IO bridge.
package mio_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRamWait = 2'd1,
    StIoWait  = 2'd2,
    StDone    = 2'd3
  } state_e;

  // Upper address nibble that routes an access to the peripheral bus.
  localparam logic [3:0]  IO_REGION    = 4'hF;
  // Read data returned when an IO access is abandoned.
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mio_wait_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
module mio_wait_cnt
  import mio_pkg::*;
#(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load takes priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mio_bridge.sv
// Memory/IO bridge between the multi-cycle controller and RAM / peripheral bus.
// Optional IO timeout is enabled by defining MIO_TIMEOUT_EN.
module mio_bridge
  import mio_pkg::*;
#(
  parameter int unsigned WAIT_RAM = 1,
  parameter int unsigned RAM_AW   = 10,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              CPU_MIO,
  input  logic              IRWrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              MIO_ready,
  output logic [31:0]       rdata,
  output logic [31:0]       Inst_out,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_dout,
  output logic              io_rd,
  output logic              io_wr,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack,
  output logic              bus_err,
  output logic [1:0]        state_out
);

  localparam int unsigned CntMax = (TIMEOUT > WAIT_RAM) ? TIMEOUT : WAIT_RAM;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d, inst_q, inst_d;
  logic        we_q, we_d;
  logic        ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic        io_rd_q, io_rd_d, io_wr_q, io_wr_d;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0] cnt_val;
  logic        req, is_io;
`ifdef MIO_TIMEOUT_EN
  logic        bus_err_q, bus_err_d;
`endif

  assign req   = CPU_MIO & (MemRead | MemWrite);
  assign is_io = (addr[31:28] == IO_REGION);

  mio_wait_cnt #(
    .Width (CntW)
  ) u_wait_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state, latched request and registered strobe decode.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    inst_d   = inst_q;
    ram_en_d = 1'b0;
    ram_we_d = 1'b0;
    io_rd_d  = 1'b0;
    io_wr_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = CntW'(WAIT_RAM);
`ifdef MIO_TIMEOUT_EN
    bus_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = MemWrite;  // write wins when both are requested
          if (is_io) begin
            state_d = StIoWait;
            io_rd_d = !MemWrite;
            io_wr_d = MemWrite;
`ifdef MIO_TIMEOUT_EN
            // Zero is reached in the TIMEOUT-th IO_WAIT cycle.
            cnt_load = 1'b1;
            cnt_val  = CntW'(TIMEOUT - 1);
`endif
          end else begin
            state_d  = StRamWait;
            ram_en_d = 1'b1;
            ram_we_d = MemWrite;
            cnt_load = 1'b1;
          end
        end
      end
      StRamWait: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = StDone;
          if (!we_q) rdata_d = ram_dout;
        end
      end
      StIoWait: begin
        io_rd_d = !we_q;
        io_wr_d = we_q;
`ifdef MIO_TIMEOUT_EN
        cnt_dec = 1'b1;
`endif
        if (io_ack) begin
          state_d = StDone;
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          if (!we_q) rdata_d = io_rdata;
        end
`ifdef MIO_TIMEOUT_EN
        else if (cnt_zero) begin
          state_d   = StDone;
          io_rd_d   = 1'b0;
          io_wr_d   = 1'b0;
          rdata_d   = BUS_ERR_DATA;
          bus_err_d = 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
        if (IRWrite) inst_d = rdata_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, data and strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      inst_q   <= '0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      io_rd_q  <= 1'b0;
      io_wr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      inst_q   <= inst_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      io_rd_q  <= io_rd_d;
      io_wr_q  <= io_wr_d;
    end
  end

`ifdef MIO_TIMEOUT_EN
  // One-cycle error flag aligned with the DONE cycle of a timed-out access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Ready is the only combinational output; forced high during reset.
  assign MIO_ready = !reset | (state_q == StDone) | ((state_q == StIdle) & !req);

  assign rdata     = rdata_q;
  assign Inst_out  = inst_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q[RAM_AW+1:2];
  assign ram_wdata = wdata_q;
  assign io_rd     = io_rd_q;
  assign io_wr     = io_wr_q;
  assign io_addr   = addr_q;
  assign io_wdata  = wdata_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_mio_bridge.sv
// Scoreboard bench for mio_bridge: random and directed accesses against a
// transaction-level model; a negedge monitor checks each completed access.
module tb_mio_bridge;

  localparam int unsigned WAIT_RAM = 1;
  localparam int unsigned RAM_AW   = 10;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned RamWords = 1 << RAM_AW;

  logic              clk = 1'b0;
  logic              reset;
  logic              MemRead, MemWrite, CPU_MIO, IRWrite;
  logic [31:0]       addr, wdata;
  logic              MIO_ready;
  logic [31:0]       rdata, Inst_out;
  logic              ram_en, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_dout;
  logic              io_rd, io_wr;
  logic [31:0]       io_addr, io_wdata, io_rdata;
  logic              io_ack;
  logic              bus_err;
  logic [1:0]        state_out;

  always #5 clk = ~clk;

  mio_bridge #(
    .WAIT_RAM (WAIT_RAM),
    .RAM_AW   (RAM_AW),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .CPU_MIO   (CPU_MIO),
    .IRWrite   (IRWrite),
    .addr      (addr),
    .wdata     (wdata),
    .MIO_ready (MIO_ready),
    .rdata     (rdata),
    .Inst_out  (Inst_out),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_dout  (ram_dout),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack),
    .bus_err   (bus_err),
    .state_out (state_out)
  );

  typedef struct {
    int unsigned t;
    int unsigned lat;
    int unsigned io_cyc;
    bit          io;
    bit          wr;
    bit          berr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [31:0] mem     [RamWords];
  logic [31:0] ref_mem [RamWords];
  logic [31:0] exp_rdata = '0;
  logic [31:0] exp_inst  = '0;
  int unsigned ack_delay = 0;
  int unsigned io_k = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int unsigned i);
    if (i == 4) return 32'h8E530000;
    return (i * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Synchronous RAM: data appears the cycle after ram_en and holds.
  initial begin
    for (int i = 0; i < RamWords; i++) mem[i] = init_word(i);
    ram_dout = '0;
    forever begin
      @(negedge clk);
      if (ram_en) begin
        ram_dout = mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_wdata;
      end
    end
  end

  // IO device: acks in the ack_delay-th strobed cycle; 0 means never.
  initial begin
    io_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (io_rd | io_wr) begin
        io_k++;
        io_ack = (ack_delay != 0) && (io_k == ack_delay);
      end else begin
        io_k   = 0;
        io_ack = 1'b0;
      end
    end
  end

  // Monitor: tally strobes per access, check each DONE against the scoreboard.
  int unsigned       n_ram_en, n_ram_we, n_io_rd, n_io_wr, ram_en_cyc;
  logic [RAM_AW-1:0] seen_ram_addr;
  logic [31:0]       seen_ram_wdata, seen_io_addr, seen_io_wdata, inst_want;
  bit                inst_pend;
  exp_t              mon_e;

  task automatic mon_clear();
    n_ram_en = 0; n_ram_we = 0; n_io_rd = 0; n_io_wr = 0; ram_en_cyc = 0;
  endtask

  initial begin
    mon_clear();
    inst_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_clear();
        inst_pend = 1'b0;
        continue;
      end
      if (inst_pend) begin
        chk("inst_out", Inst_out, inst_want);
        inst_pend = 1'b0;
      end
      if (ram_en) begin
        n_ram_en++;
        ram_en_cyc     = cyc;
        seen_ram_addr  = ram_addr;
        seen_ram_wdata = ram_wdata;
      end
      if (ram_we) n_ram_we++;
      if (io_rd) n_io_rd++;
      if (io_wr) n_io_wr++;
      if (io_rd | io_wr) begin
        seen_io_addr  = io_addr;
        seen_io_wdata = io_wdata;
      end
      if (state_out == 2'd1 || state_out == 2'd2) chk("busy_ready", 32'(MIO_ready), 32'd0);
      if (state_out == 2'd3) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: DONE with empty scoreboard at cycle %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("latency", cyc - mon_e.t, mon_e.lat);
          chk("done_ready", 32'(MIO_ready), 32'd1);
          chk("rdata", rdata, mon_e.rdata);
          chk("bus_err", 32'(bus_err), 32'(mon_e.berr));
          chk("ram_en_cnt", n_ram_en, mon_e.io ? 32'd0 : 32'd1);
          chk("ram_we_cnt", n_ram_we, (!mon_e.io && mon_e.wr) ? 32'd1 : 32'd0);
          chk("io_rd_cnt", n_io_rd, (mon_e.io && !mon_e.wr) ? mon_e.io_cyc : 32'd0);
          chk("io_wr_cnt", n_io_wr, (mon_e.io && mon_e.wr) ? mon_e.io_cyc : 32'd0);
          if (!mon_e.io) begin
            chk("ram_en_cycle", ram_en_cyc, mon_e.t + 1);
            chk("ram_addr", 32'(seen_ram_addr), 32'(mon_e.addr[RAM_AW+1:2]));
            if (mon_e.wr) chk("ram_wdata", seen_ram_wdata, mon_e.wdata);
          end else begin
            chk("io_addr", seen_io_addr, mon_e.addr);
            if (mon_e.wr) chk("io_wdata", seen_io_wdata, mon_e.wdata);
          end
          inst_pend = 1'b1;
          inst_want = mon_e.inst;
        end
        mon_clear();
      end
    end
  end

  // Reference model: predicts the outcome of one access issued now.
  task automatic push_exp(bit io, bit wr, logic [31:0] a, logic [31:0] d, bit irw,
                          int unsigned k, logic [31:0] v);
    exp_t e;
    logic [RAM_AW-1:0] idx;
    e.t = cyc; e.io = io; e.wr = wr; e.addr = a; e.wdata = d; e.berr = 1'b0; e.io_cyc = k;
    if (io) begin
      if (k == 0) begin
        e.lat = TIMEOUT + 1; e.io_cyc = TIMEOUT; e.berr = 1'b1;
        exp_rdata = 32'hDEADBEEF;
      end else begin
        e.lat = k + 1;
        if (!wr) exp_rdata = v;
      end
    end else begin
      e.lat = 2 + WAIT_RAM;
      idx = a[RAM_AW+1:2];
      if (wr) ref_mem[idx] = d;
      else    exp_rdata = ref_mem[idx];
    end
    if (irw) exp_inst = exp_rdata;
    e.rdata = exp_rdata;
    e.inst  = exp_inst;
    sb.push_back(e);
  endtask

  // Present a request at the negedge of an IDLE cycle.
  task automatic issue(bit io, bit wr, bit both, logic [31:0] a, logic [31:0] d, bit irw,
                       int unsigned k, logic [31:0] v);
    push_exp(io, wr, a, d, irw, k, v);
    CPU_MIO = 1'b1; MemWrite = wr; MemRead = !wr | both;
    addr = a; wdata = d; IRWrite = irw; ack_delay = k; io_rdata = v;
    #1 chk("req_ready", 32'(MIO_ready), 32'd0);
  endtask

  // Drop the request after it is latched and scramble the bus.
  task automatic release_req();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'($urandom);
    addr = $urandom; wdata = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (state_out == 2'd3) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no DONE expected DONE within 200 cycles");
    finish_now();
  endtask

  task automatic run(bit io, bit wr, bit both, logic [31:0] a, logic [31:0] d, bit irw,
                     int unsigned k, logic [31:0] v);
    issue(io, wr, both, a, d, irw, k, v);
    release_req();
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, d;
    bit          io, wr, both, irw;
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0; IRWrite = 1'b0;
    addr = '0; wdata = '0; io_rdata = '0;
    for (int i = 0; i < RamWords; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_ready", 32'(MIO_ready), 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_inst", Inst_out, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed: lw with IRWrite, sw, IO read with ack in the third cycle.
    run(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 0, 32'h0);
    run(1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 1'b0, 0, 32'h0);
    run(1'b1, 1'b0, 1'b0, 32'hF0000004, 32'h0, 1'b0, 3, 32'hA5);

    // Request without CPU_MIO is not an access.
    MemRead = 1'b1; MemWrite = 1'b1; CPU_MIO = 1'b0; addr = 32'h30;
    #1 chk("nomio_ready", 32'(MIO_ready), 32'd1);
    @(negedge clk);
    chk("nomio_state", 32'(state_out), 32'd0);
    MemRead = 1'b0; MemWrite = 1'b0;

    // Back-to-back: request held through DONE restarts as a write.
    d = $urandom;
    issue(1'b0, 1'b1, 1'b1, 32'h44, d, 1'b0, 0, 32'h0);
    wait_done();
    @(negedge clk);
    push_exp(1'b0, 1'b1, 32'h44, d, 1'b0, 0, 32'h0);
    #1 chk("b2b_ready", 32'(MIO_ready), 32'd0);
    release_req();
    wait_done();
    @(negedge clk);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      io   = ($urandom % 3) == 0;
      wr   = 1'($urandom);
      both = wr & 1'($urandom);
      irw  = 1'($urandom);
      a    = io ? {4'hF, 28'($urandom)} : {4'($urandom_range(0, 14)), 28'($urandom)};
      d    = $urandom;
      run(io, wr, both, a, d, irw, $urandom_range(1, 6), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef MIO_TIMEOUT_EN
    run(1'b1, 1'b0, 1'b0, 32'hF0000010, 32'h0, 1'b1, 0, 32'h55);
`endif

    // IO read that is never acknowledged.
    issue(1'b1, 1'b0, 1'b0, 32'hF0000008, 32'h0, 1'b0, 0, 32'h77);
    release_req();
`ifndef MIO_TIMEOUT_EN
    repeat (20) begin
      @(negedge clk);
      chk("hang_state", 32'(state_out), 32'd2);
      chk("hang_ready", 32'(MIO_ready), 32'd0);
    end
`else
    repeat (5) @(negedge clk);
`endif

    // Asynchronous reset in the middle of IO_WAIT, with a request held.
    MemRead = 1'b1; CPU_MIO = 1'b1; addr = 32'hF0000000;
    #2 reset = 1'b0;
    #1;
    chk("arst_io_rd", 32'(io_rd), 32'd0);
    chk("arst_state", 32'(state_out), 32'd0);
    chk("arst_ready", 32'(MIO_ready), 32'd1);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_inst", Inst_out, 32'd0);
    chk("arst_bus_err", 32'(bus_err), 32'd0);
    sb.delete();
    exp_rdata = '0;
    exp_inst  = '0;
    MemRead = 1'b0; CPU_MIO = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run(1'b0, 1'b0, 1'b0, {4'h1, 28'($urandom)}, 32'h0, 1'b1, 0, 32'h0);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    finish_now();
  end

endmodule

// File: doc/mio_bridge.md
# mio_bridge

Memory/IO bus bridge between the multi-cycle controller (MCtrl) and the datapath on one side, and the synchronous instruction/data RAM and the peripheral bus on the other. It decodes each controller access into a RAM or IO access, inserts wait states, and generates the `MIO_ready` handshake that stalls MCtrl. It also holds the read-data register (MDR) and the instruction register that drives MCtrl's `Inst_in`.

## Interface
- `WAIT_RAM`, 1: RAM wait states; must be ≥1.
- `RAM_AW`, 10: RAM word-address width.
- `TIMEOUT`, 16: IO wait limit in cycles; used only with the macro.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `MemRead` in 1: read request from MCtrl.
- `MemWrite` in 1: write request from MCtrl.
- `CPU_MIO` in 1: bus-access qualifier from MCtrl.
- `IRWrite` in 1: load the instruction register at DONE exit.
- `addr` in 32: byte address; the datapath muxes it via IorD.
- `wdata` in 32: store data.
- `MIO_ready` out 1: access complete or no request.
- `rdata` out 32: MDR.
- `Inst_out` out 32: instruction register; connects to MCtrl `Inst_in`.
- `ram_en` out 1, `ram_we` out 1: RAM strobes.
- `ram_addr` out RAM_AW: equals `addr[RAM_AW+1:2]`.
- `ram_wdata` out 32: RAM write data.
- `ram_dout` in 32: RAM read data, valid one cycle after `ram_en`.
- `io_rd` out 1, `io_wr` out 1: IO strobes.
- `io_addr` out 32: IO address.
- `io_wdata` out 32: IO write data.
- `io_rdata` in 32: IO read data.
- `io_ack` in 1: IO completion.
- `bus_err` out 1: timeout pulse.
- `state_out` out 2: current state, for debug.

## Operation
- Request: `req = CPU_MIO & (MemRead | MemWrite)`. If both are high, the access is a write.
- Region decode: `addr[31:28]==4'hF` selects IO; anything else selects RAM.
- States:
  - IDLE (0):
    - RAM request goes to RAM_WAIT, with the counter loaded to WAIT_RAM.
    - IO request goes to IO_WAIT.
    - `addr`, `wdata` and the read/write direction are latched on this edge.
  - RAM_WAIT (1):
    - First cycle only: `ram_en`=1, and `ram_we`=1 if the access is a write.
    - The counter decrements each cycle.
    - In the cycle the counter is 0: `rdata<=ram_dout` (reads only), then go to DONE.
  - IO_WAIT (2):
    - `io_rd` or `io_wr` is held high every cycle.
    - When `io_ack` is sampled 1: `rdata<=io_rdata` (reads only), then go to DONE.
  - DONE (3):
    - One cycle; `MIO_ready`=1.
    - Exit edge: `Inst_out<=rdata` if `IRWrite`.
    - Always returns to IDLE. A request still held is treated as a new access.
- `MIO_ready` is combinational: 1 in DONE, 1 in IDLE with `!req`, 0 otherwise.
- Dropping `req` mid-access does not abort the access; it completes normally.
- Writes leave `rdata` unchanged.

## Timing
- Request at cycle t (IDLE):
  - RAM: `MIO_ready` is low for cycles t..t+1+WAIT_RAM and high at t+2+WAIT_RAM.
  - IO: with `io_ack` sampled high in cycle t+k (k≥1), DONE is at t+k+1.
- `ram_en` is exactly one cycle, at t+1.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All strobes go to 0.
  - `rdata`=0, `Inst_out`=0, `bus_err`=0.
  - `MIO_ready`=1 while `reset` is low.
- Strobes and `state_out` are registered, with no combinational path from inputs. The only combinational output is `MIO_ready`.

## Configuration
- `MIO_TIMEOUT_EN` defined:
  - In IO_WAIT, a timer counts cycles.
  - If `io_ack` is not seen within TIMEOUT cycles, the block goes to DONE with `rdata=32'hDEADBEEF`.
  - `bus_err`=1 for that DONE cycle only.
- Undefined:
  - IO_WAIT waits indefinitely.
  - `bus_err` is tied to 0.
  - No timer logic is generated.

## Structure
- Package `mio_pkg`:
  - State enum: IDLE=2'd0, RAM_WAIT=2'd1, IO_WAIT=2'd2, DONE=2'd3.
  - `IO_REGION=4'hF`.
  - `BUS_ERR_DATA=32'hDEADBEEF`.
- One sub-module, `mio_wait_cnt`: a loadable down-counter with a zero flag. It is shared by the RAM wait count and the IO timeout.

## Test plan
- Reset asserted low mid IO_WAIT -> `io_rd`=0 and `state_out`=0 immediately; `MIO_ready`=1; `rdata`=`Inst_out`=0.
- lw from RAM, `addr`=0x10, WAIT_RAM=1, `ram_dout`=0x8E530000, request at t, `IRWrite`=1 ->
  - `ram_en` high at t+1 only, `ram_addr`=4.
  - `MIO_ready` low t..t+2, high t+3.
  - `rdata`=0x8E530000; `Inst_out`=0x8E530000 from t+4.
- sw to RAM, `addr`=0x20, `wdata`=0x12345678 -> `ram_en`=`ram_we`=1 at t+1 only; `ram_wdata`=0x12345678; `rdata` unchanged.
- IO read, `addr`=0xF0000004, `io_ack` high at t+3, `io_rdata`=0xA5 -> `io_rd` high t+1..t+3; DONE at t+4; `rdata`=0x000000A5.
- IO read, `io_ack` never asserted ->
  - With `MIO_TIMEOUT_EN`: DONE at t+17, `rdata`=0xDEADBEEF, `bus_err` pulse of one cycle.
  - Without: `state_out` stays 2 and `MIO_ready` stays 0.
- Back-to-back requests held through DONE, with `MemRead`=`MemWrite`=1 -> IDLE restarts an access the next cycle as a write; `MIO_ready` returns to 0.
